// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared types and constants for the multiplexed seven-segment
//               display driver: segment vector type, blanked pattern and the
//               active-low hex glyphs {g,f,e,d,c,b,a}.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

  // Active-low segment vector, bit order {g,f,e,d,c,b,a}
  typedef logic [6:0] seg_t;

  // All segments dark
  localparam seg_t SEG_OFF = 7'b1111111;

  // Hex glyphs 0-F
  localparam seg_t SEG_HEX_0 = 7'b1000000;
  localparam seg_t SEG_HEX_1 = 7'b1111001;
  localparam seg_t SEG_HEX_2 = 7'b0100100;
  localparam seg_t SEG_HEX_3 = 7'b0110000;
  localparam seg_t SEG_HEX_4 = 7'b0011001;
  localparam seg_t SEG_HEX_5 = 7'b0010010;
  localparam seg_t SEG_HEX_6 = 7'b0000010;
  localparam seg_t SEG_HEX_7 = 7'b1111000;
  localparam seg_t SEG_HEX_8 = 7'b0000000;
  localparam seg_t SEG_HEX_9 = 7'b0010000;
  localparam seg_t SEG_HEX_A = 7'b0001000;
  localparam seg_t SEG_HEX_B = 7'b0000011;
  localparam seg_t SEG_HEX_C = 7'b1000110;
  localparam seg_t SEG_HEX_D = 7'b0100001;
  localparam seg_t SEG_HEX_E = 7'b0000110;
  localparam seg_t SEG_HEX_F = 7'b0001110;

  // Digit-index width: a single-digit display still needs a 1-bit index
  function automatic int seg_idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg_hex_decoder
// Description : Combinational nibble to active-low seven-segment decoder,
//               full hex range 0-F.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  // Glyph lookup; every nibble value has a pattern
  always_comb begin
    o_seg = SEG_OFF;
    case (i_nibble)
      4'h0: o_seg = SEG_HEX_0;
      4'h1: o_seg = SEG_HEX_1;
      4'h2: o_seg = SEG_HEX_2;
      4'h3: o_seg = SEG_HEX_3;
      4'h4: o_seg = SEG_HEX_4;
      4'h5: o_seg = SEG_HEX_5;
      4'h6: o_seg = SEG_HEX_6;
      4'h7: o_seg = SEG_HEX_7;
      4'h8: o_seg = SEG_HEX_8;
      4'h9: o_seg = SEG_HEX_9;
      4'hA: o_seg = SEG_HEX_A;
      4'hB: o_seg = SEG_HEX_B;
      4'hC: o_seg = SEG_HEX_C;
      4'hD: o_seg = SEG_HEX_D;
      4'hE: o_seg = SEG_HEX_E;
      4'hF: o_seg = SEG_HEX_F;
      default: o_seg = SEG_OFF;
    endcase
  end

endmodule : seg_hex_decoder
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Multiplexed seven-segment display driver. Latches DIGITS hex
//               nibbles on a parallel-load strobe and scans them onto one
//               shared active-low segment bus with one-hot active-low anodes.
//               Each digit window starts with a dark guard cycle to avoid
//               ghosting; a frame pulse marks the guard cycle of digit 0.
//               Optional feature macro: SEG_LZB_EN (leading-zero blanking).
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pl,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   din,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int PCNT_W = $clog2(PRESCALE);
  localparam int IDX_W  = seg_idx_width(DIGITS);

  localparam logic [PCNT_W-1:0] c_PCNT_LAST = PCNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0]  c_IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [4*DIGITS-1:0] r_shadow;
  logic [PCNT_W-1:0]   r_pcnt;
  logic [IDX_W-1:0]    r_idx;
  seg_t                r_seg;
  logic [DIGITS-1:0]   r_an;
  logic                r_frame;

  logic                w_guard;
  logic                w_idx_last;
  logic [DIGITS-1:0]   w_an_sel;
  logic [3:0]          w_nibble;
  seg_t                w_dec;
  seg_t                w_active_seg;

  assign w_guard    = (r_pcnt == '0);
  assign w_idx_last = (r_idx == c_IDX_LAST);
  assign w_an_sel   = ~(DIGITS'(1) << r_idx);

  // Select the nibble of the digit currently being scanned
  always_comb begin
    w_nibble = 4'h0;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_nibble = r_shadow[4*k +: 4];
      end
    end
  end

  seg_hex_decoder u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_dec)
  );

`ifdef SEG_LZB_EN
  // Bit k set when digit k (k>0) and every more significant digit are zero
  logic [DIGITS-1:0] w_lz_mask;

  // Walk from the most significant digit down while the run of zeros holds
  always_comb begin
    logic v_zero_run;
    v_zero_run = 1'b1;
    w_lz_mask  = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      v_zero_run   = v_zero_run & (r_shadow[4*k +: 4] == 4'h0);
      w_lz_mask[k] = v_zero_run;
    end
  end

  // The active anode bit (low in w_an_sel) picks the blanking flag
  assign w_active_seg = (|(w_lz_mask & ~w_an_sel)) ? SEG_OFF : w_dec;
`else
  assign w_active_seg = w_dec;
`endif

  // Shadow register: loads regardless of scan enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (pl) begin
      r_shadow <= din;
    end
  end

  // Prescale counter and digit index advance only while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
      r_idx  <= '0;
    end else if (en) begin
      if (r_pcnt == c_PCNT_LAST) begin
        r_pcnt <= '0;
        r_idx  <= w_idx_last ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_pcnt <= r_pcnt + PCNT_W'(1);
      end
    end
  end

  // Registered pin drivers: dark on the guard cycle, glyph otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= SEG_OFF;
      r_an  <= '1;
    end else if (en) begin
      if (w_guard) begin
        r_seg <= SEG_OFF;
        r_an  <= '1;
      end else begin
        r_seg <= w_active_seg;
        r_an  <= w_an_sel;
      end
    end
  end

  // Frame marker: a single-cycle pulse on the enabled guard cycle of digit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= 1'b0;
    end else begin
      r_frame <= en & w_guard & (r_idx == '0);
    end
  end

  assign seg   = r_seg;
  assign an    = r_an;
  assign frame = r_frame;

endmodule : seg_scan_driver
`default_nettype wire
